// File: rtl/motion_sequencer.sv
// motion_sequencer
//   Timed navigation FSM feeding the motor controller. Converts start/stop
//   requests, an emergency stop and three obstacle sensors into five one-hot
//   drive commands. The front sensor is debounced. Turn and rotate manoeuvres
//   last a fixed number of cycles, set by a down-counter. Completed
//   manoeuvres are counted.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : asynchronous, active-high reset
//   start          : level, request motion from IDLE or HALT
//   stop_req       : level, return to IDLE from any moving state
//   estop          : level, emergency stop (highest priority)
//   obstacle_front : front sensor, 1 = obstacle
//   obstacle_left  : left sensor, 1 = blocked
//   obstacle_right : right sensor, 1 = blocked
//   stop_motor, front_motor, turn_left, turn_right, rotate : one-hot commands
//   halted         : high while in HALT
//   maneuver_cnt   : completed manoeuvres, saturating at 255
module motion_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TURN_CYCLES     = 8,
    parameter int ROTATE_CYCLES   = 16,
    parameter int TIMER_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop_req,
    input  logic       estop,
    input  logic       obstacle_front,
    input  logic       obstacle_left,
    input  logic       obstacle_right,
    output logic       stop_motor,
    output logic       front_motor,
    output logic       turn_left,
    output logic       turn_right,
    output logic       rotate,
    output logic       halted,
    output logic [7:0] maneuver_cnt
);

    // The debounce counter only ever reaches DEBOUNCE_CYCLES-1
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ROT_LOAD  = TIMER_W'(ROTATE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || TURN_CYCLES < 1 || ROTATE_CYCLES < 1) begin : g_bad_cycles
        $error("motion_sequencer: cycle parameters must be >= 1");
    end
    if (TIMER_W < 1 || TIMER_W > 31 ||
        longint'(TURN_CYCLES)   > (longint'(1) << TIMER_W) ||
        longint'(ROTATE_CYCLES) > (longint'(1) << TIMER_W)) begin : g_bad_timer
        $error("motion_sequencer: TIMER_W too narrow for the manoeuvre lengths");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_TURN_L = 3'd2,
        S_TURN_R = 3'd3,
        S_ROTATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DEB_W-1:0]   r_deb;
    logic [TIMER_W-1:0] r_timer;
    logic [7:0]         r_cnt;

    logic w_in_man;     // currently in a timed manoeuvre
    logic w_man_next;   // next state is a timed manoeuvre
    logic w_accept;     // debounced front obstacle accepted this edge
    logic w_done;       // manoeuvre finishes normally on this edge

    assign w_in_man   = (r_state == S_TURN_L) || (r_state == S_TURN_R) || (r_state == S_ROTATE);
    assign w_man_next = (w_next == S_TURN_L) || (w_next == S_TURN_R) || (w_next == S_ROTATE);
    assign w_accept   = (r_state == S_FWD) && obstacle_front && (r_deb == DEB_LAST);
    // w_next is FORWARD only when neither estop nor stop_req intervened
    assign w_done     = w_in_man && (r_timer == '0) && (w_next == S_FWD);

    always_comb begin
        w_next = r_state;
        if (estop) begin
            w_next = S_HALT;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) w_next = S_FWD;
                end
                S_FWD: begin
                    if (stop_req) begin
                        w_next = S_IDLE;
                    end else if (w_accept) begin
                        // Left is preferred when both sides are clear
                        if (!obstacle_left)       w_next = S_TURN_L;
                        else if (!obstacle_right) w_next = S_TURN_R;
                        else                      w_next = S_ROTATE;
                    end
                end
                S_TURN_L, S_TURN_R, S_ROTATE: begin
                    if (stop_req)              w_next = S_IDLE;
                    else if (r_timer == '0)    w_next = S_FWD;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_deb   <= '0;
            r_timer <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;

            // Streak of high front samples; cleared on a low sample or on leaving FORWARD
            if (r_state == S_FWD && w_next == S_FWD && obstacle_front)
                r_deb <= r_deb + 1'b1;
            else
                r_deb <= '0;

            if (r_state == S_FWD && (w_next == S_TURN_L || w_next == S_TURN_R))
                r_timer <= TURN_LOAD;
            else if (r_state == S_FWD && w_next == S_ROTATE)
                r_timer <= ROT_LOAD;
            else if (w_man_next)
                r_timer <= r_timer - 1'b1;
            else
                r_timer <= '0;

            if (w_done && r_cnt != 8'hFF)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Moore decode; unknown encodings show stop_motor so one-hot always holds
    always_comb begin
        stop_motor  = 1'b0;
        front_motor = 1'b0;
        turn_left   = 1'b0;
        turn_right  = 1'b0;
        rotate      = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_FWD:    front_motor = 1'b1;
            S_TURN_L: turn_left   = 1'b1;
            S_TURN_R: turn_right  = 1'b1;
            S_ROTATE: rotate      = 1'b1;
            S_HALT: begin
                stop_motor = 1'b1;
                halted     = 1'b1;
            end
            default:  stop_motor  = 1'b1;
        endcase
    end

    assign maneuver_cnt = r_cnt;

endmodule

// File: tb/tb_motion_sequencer.sv
// Testbench for motion_sequencer: table-driven vectors, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_motion_sequencer;

    localparam int D = 4;
    localparam int T = 8;
    localparam int R = 16;

    localparam logic [4:0] C_STOP = 5'b10000;
    localparam logic [4:0] C_FWD  = 5'b01000;
    localparam logic [4:0] C_TL   = 5'b00100;
    localparam logic [4:0] C_TR   = 5'b00010;
    localparam logic [4:0] C_ROT  = 5'b00001;

    localparam int M_IDLE = 0, M_FWD = 1, M_TL = 2, M_TR = 3, M_ROT = 4, M_HALT = 5;

    logic clk = 1'b0;
    logic reset, start, stop_req, estop, obstacle_front, obstacle_left, obstacle_right;
    logic stop_motor, front_motor, turn_left, turn_right, rotate, halted;
    logic [7:0] maneuver_cnt;

    motion_sequencer #(
        .DEBOUNCE_CYCLES(D), .TURN_CYCLES(T), .ROTATE_CYCLES(R), .TIMER_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop_req(stop_req), .estop(estop),
        .obstacle_front(obstacle_front), .obstacle_left(obstacle_left),
        .obstacle_right(obstacle_right), .stop_motor(stop_motor), .front_motor(front_motor),
        .turn_left(turn_left), .turn_right(turn_right), .rotate(rotate), .halted(halted),
        .maneuver_cnt(maneuver_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: current mode, run of high front samples, cycles left in manoeuvre
    int m_mode, m_streak, m_left, m_cnt;

    function automatic void model_reset();
        m_mode = M_IDLE; m_streak = 0; m_left = 0; m_cnt = 0;
    endfunction

    function automatic void model_edge(bit s, bit sr, bit es, bit of, bit ol, bit orr);
        bit moving;
        moving = (m_mode != M_IDLE) && (m_mode != M_HALT);
        if (es) begin
            m_mode = M_HALT; m_streak = 0; m_left = 0;
        end else if (sr && moving) begin
            m_mode = M_IDLE; m_streak = 0; m_left = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALT: if (s) m_mode = M_FWD;
                M_FWD: begin
                    if (of) begin
                        m_streak++;
                        if (m_streak == D) begin
                            m_streak = 0;
                            if (!ol)       begin m_mode = M_TL;  m_left = T; end
                            else if (!orr) begin m_mode = M_TR;  m_left = T; end
                            else           begin m_mode = M_ROT; m_left = R; end
                        end
                    end else begin
                        m_streak = 0;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_FWD;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            endcase
        end
    endfunction

    function automatic logic [13:0] model_out();
        logic [4:0] c;
        case (m_mode)
            M_FWD:   c = C_FWD;
            M_TL:    c = C_TL;
            M_TR:    c = C_TR;
            M_ROT:   c = C_ROT;
            default: c = C_STOP;
        endcase
        return {c, (m_mode == M_HALT), 8'(m_cnt)};
    endfunction

    function automatic logic [13:0] dut_out();
        return {stop_motor, front_motor, turn_left, turn_right, rotate, halted, maneuver_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit s, input bit sr, input bit es, input bit of, input bit ol, input bit orr);
        start = s; stop_req = sr; estop = es;
        obstacle_front = of; obstacle_left = ol; obstacle_right = orr;
    endtask

    // One clock: drive, advance model, sample 1ns after the edge, compare
    task automatic cycle(input bit s, input bit sr, input bit es, input bit of, input bit ol, input bit orr);
        drive(s, sr, es, of, ol, orr);
        model_edge(s, sr, es, of, ol, orr);
        @(posedge clk);
        #1;
        check("cycle", 32'(dut_out()), 32'(model_out()));
        check("onehot", 32'($onehot({stop_motor, front_motor, turn_left, turn_right, rotate})), 32'd1);
    endtask

    typedef struct {
        bit s, sr, es, of, ol, orr;
        logic [13:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(int n, bit s, bit sr, bit es, bit of, bit ol, bit orr,
                                logic [4:0] c, bit h, logic [7:0] cnt);
        vec_t v;
        v.s = s; v.sr = sr; v.es = es; v.of = of; v.ol = ol; v.orr = orr;
        v.exp = {c, h, cnt};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] saved;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check("reset_async", 32'(dut_out()), 32'({C_STOP, 1'b0, 8'd0}));
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 32'(dut_out()), 32'({C_STOP, 1'b0, 8'd0}));
        reset = 1'b0;

        // start+stop_req in IDLE goes forward; 3-cycle glitch ignored; left turn
        add(1, 1, 1, 0, 0, 0, 0, C_FWD, 0, 0);
        add(3, 0, 0, 0, 1, 0, 0, C_FWD, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, C_FWD, 0, 0);
        add(3, 0, 0, 0, 1, 0, 0, C_FWD, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, C_TL,  0, 0);
        add(7, 0, 0, 0, 0, 0, 0, C_TL,  0, 0);
        add(1, 0, 0, 0, 0, 0, 0, C_FWD, 0, 1);
        // right turn
        add(3, 0, 0, 0, 1, 1, 0, C_FWD, 0, 1);
        add(1, 0, 0, 0, 1, 1, 0, C_TR,  0, 1);
        add(7, 0, 0, 0, 0, 0, 0, C_TR,  0, 1);
        add(1, 0, 0, 0, 0, 0, 0, C_FWD, 0, 2);
        // rotate, sensors active but ignored during the manoeuvre
        add(3, 0, 0, 0, 1, 1, 1, C_FWD, 0, 2);
        add(1, 0, 0, 0, 1, 1, 1, C_ROT, 0, 2);
        add(15, 0, 0, 0, 1, 1, 1, C_ROT, 0, 2);
        add(1, 0, 0, 0, 0, 0, 0, C_FWD, 0, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].s, tbl[i].sr, tbl[i].es, tbl[i].of, tbl[i].ol, tbl[i].orr);
            model_edge(tbl[i].s, tbl[i].sr, tbl[i].es, tbl[i].of, tbl[i].ol, tbl[i].orr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
        end

        // estop during the 5th rotate cycle
        repeat (4) cycle(0, 0, 0, 1, 1, 1);
        repeat (4) cycle(0, 0, 0, 0, 0, 0);
        check("rot_c5", 32'(dut_out()), 32'({C_ROT, 1'b0, 8'd3}));
        cycle(0, 0, 1, 0, 0, 0);
        check("estop_halt", 32'(dut_out()), 32'({C_STOP, 1'b1, 8'd3}));
        cycle(1, 0, 1, 0, 0, 0);
        check("halt_estop_start", 32'(dut_out()), 32'({C_STOP, 1'b1, 8'd3}));
        cycle(1, 0, 0, 0, 0, 0);
        check("halt_resume", 32'(dut_out()), 32'({C_FWD, 1'b0, 8'd3}));

        // stop_req at turn_left cycle 3
        repeat (4) cycle(0, 0, 0, 1, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("stopreq_idle", 32'(dut_out()), 32'({C_STOP, 1'b0, 8'd3}));
        cycle(1, 0, 0, 0, 0, 0);

        // estop on the expiry edge: HALT, not counted
        repeat (4) cycle(0, 0, 0, 1, 0, 0);
        repeat (7) cycle(0, 0, 0, 0, 0, 0);
        check("tl_last", 32'(dut_out()), 32'({C_TL, 1'b0, 8'd3}));
        cycle(0, 0, 1, 0, 0, 0);
        check("estop_expiry", 32'(dut_out()), 32'({C_STOP, 1'b1, 8'd3}));
        cycle(1, 0, 0, 0, 0, 0);

        // asynchronous reset between edges mid-turn
        repeat (4) cycle(0, 0, 0, 1, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("reset_midturn", 32'(dut_out()), 32'({C_STOP, 1'b0, 8'd0}));
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // saturation after 256 completed manoeuvres
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 256; k++) begin
            repeat (4) cycle(0, 0, 0, 1, 0, 0);
            repeat (8) cycle(0, 0, 0, 0, 0, 0);
            if (k == 254) check("cnt_255", 32'(maneuver_cnt), 32'd255);
        end
        check("cnt_sat", 32'(maneuver_cnt), 32'd255);

        // randomized run from a fresh reset against the model
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        saved = 8'd0;
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(1) == 1), ($urandom_range(19) == 0), ($urandom_range(29) == 0),
                  ($urandom_range(2) != 0), ($urandom_range(1) == 1), ($urandom_range(1) == 1));
            if (maneuver_cnt > saved) saved = maneuver_cnt;
        end
        check("rand_progress", 32'(saved > 8'd0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
